// File: rtl/multi_phase_controller.sv
// Day-cycle sequencer: per phase read light over SPI, show it, take a run time
// over UART, then drive motor/heater for that many seconds.
module multi_phase_controller #(
    parameter int unsigned ONE_SECOND      = 50_000_000,
    parameter int unsigned NUM_PHASES      = 2,
    parameter logic [7:0]  DEFAULT_RUN_SEC = 8'd10,
    parameter logic [7:0]  LIGHT_THRESH    = 8'h80
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  bt_start,
    input  logic                  bt_setting,
    input  logic                  bt_abort,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic [7:0]            led_data,
    input  logic                  spi_done,
    output logic                  spi_req,
    output logic                  motor_signal,
    output logic                  heat_signal,
    output logic [7:0]            led_out,
    output logic [7:0]            remain_sec,
    output logic [NUM_PHASES-1:0] phase_active,
    output logic                  Day_done
);

    localparam int unsigned TW = (ONE_SECOND > 1) ? $clog2(ONE_SECOND) : 1;
    localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(ONE_SECOND - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHT_READ,
        S_DISPLAY,
        S_SETTING,
        S_RUNNING,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [7:0]      run_sec_q, run_sec_d;
    logic [7:0]      remain_q, remain_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      led_q, led_d;
    logic            start_prev_q, setting_prev_q, abort_prev_q;
    logic            spi_req_q, motor_q, heat_q, done_q;
    logic [NUM_PHASES-1:0] active_q, active_d;

    logic            start_e, setting_e, abort_e;
    logic [7:0]      rx_sec;
    logic            in_phase;

    assign start_e   = bt_start & ~start_prev_q;
    assign setting_e = bt_setting & ~setting_prev_q;
    assign abort_e   = bt_abort & ~abort_prev_q;
    assign rx_sec    = (rx_data == 8'd0) ? DEFAULT_RUN_SEC : rx_data;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        run_sec_d = run_sec_q;
        remain_d  = remain_q;
        tick_d    = tick_q;
        led_d     = led_q;
        // Abort outranks every other event; light and run time survive it.
        if (abort_e && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            phase_d  = '0;
            remain_d = 8'd0;
            tick_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_e) begin
                        state_d = S_LIGHT_READ;
                        phase_d = '0;
                    end
                end
                S_LIGHT_READ: begin
                    if (spi_done) begin
                        led_d   = led_data;
                        state_d = S_DISPLAY;
                    end
                end
                S_DISPLAY: state_d = S_SETTING;
                S_SETTING: begin
                    if (rx_done) run_sec_d = rx_sec;
                    if (setting_e) begin
                        state_d  = S_RUNNING;
                        remain_d = rx_done ? rx_sec : run_sec_q;
                        tick_d   = '0;
                    end
                end
                S_RUNNING: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (remain_q != 8'd0) remain_d = remain_q - 8'd1;
                        if (remain_q <= 8'd1) begin
                            if (phase_q == PHASE_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_LIGHT_READ;
                                phase_d = phase_q + 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (start_e) begin
                        state_d = S_LIGHT_READ;
                        phase_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_phase = (state_d == S_LIGHT_READ) || (state_d == S_DISPLAY) ||
                      (state_d == S_SETTING) || (state_d == S_RUNNING);

    always_comb begin
        active_d = '0;
        if (in_phase) active_d = NUM_PHASES'(1) << phase_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            run_sec_q      <= DEFAULT_RUN_SEC;
            remain_q       <= 8'd0;
            tick_q         <= '0;
            led_q          <= 8'd0;
            start_prev_q   <= 1'b0;
            setting_prev_q <= 1'b0;
            abort_prev_q   <= 1'b0;
            spi_req_q      <= 1'b0;
            motor_q        <= 1'b0;
            heat_q         <= 1'b0;
            done_q         <= 1'b0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            run_sec_q      <= run_sec_d;
            remain_q       <= remain_d;
            tick_q         <= tick_d;
            led_q          <= led_d;
            start_prev_q   <= bt_start;
            setting_prev_q <= bt_setting;
            abort_prev_q   <= bt_abort;
            spi_req_q      <= (state_d == S_LIGHT_READ);
            motor_q        <= (state_d == S_RUNNING);
            heat_q         <= (state_d == S_RUNNING) && (led_d < LIGHT_THRESH);
            done_q         <= (state_d == S_DONE);
            active_q       <= active_d;
        end
    end

    assign spi_req      = spi_req_q;
    assign motor_signal = motor_q;
    assign heat_signal  = heat_q;
    assign led_out      = led_q;
    assign remain_sec   = remain_q;
    assign phase_active = active_q;
    assign Day_done     = done_q;

endmodule

// File: tb/tb_multi_phase_controller.sv
// Bench for multi_phase_controller: vector table, directed corner cases and
// random stimulus against a cycle-count reference model.
module tb_multi_phase_controller;

    localparam int OS = 10;
    localparam int NP = 2;

    localparam int M_IDLE = 0;
    localparam int M_LR   = 1;
    localparam int M_DISP = 2;
    localparam int M_SET  = 3;
    localparam int M_RUN  = 4;
    localparam int M_DONE = 5;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic bt_start = 1'b0, bt_setting = 1'b0, bt_abort = 1'b0;
    logic rx_done = 1'b0, spi_done = 1'b0;
    logic [7:0] rx_data = 8'd0, led_data = 8'd0;

    logic spi_req, motor_signal, heat_signal, Day_done;
    logic [7:0] led_out, remain_sec;
    logic [NP-1:0] phase_active;

    logic spi_req4, motor4, heat4, done4;
    logic [7:0] led4, remain4;
    logic [3:0] pa4;

    int n_tests = 0;
    int n_fail = 0;
    bit mchk = 1'b1;

    int m_st, m_ph, m_light, m_run, m_left;
    bit m_ps, m_pse, m_pa;

    multi_phase_controller #(.ONE_SECOND(OS), .NUM_PHASES(NP)) u_dut (
        .clk(clk), .n_rst(n_rst),
        .bt_start(bt_start), .bt_setting(bt_setting), .bt_abort(bt_abort),
        .rx_data(rx_data), .rx_done(rx_done),
        .led_data(led_data), .spi_done(spi_done),
        .spi_req(spi_req), .motor_signal(motor_signal),
        .heat_signal(heat_signal), .led_out(led_out),
        .remain_sec(remain_sec), .phase_active(phase_active),
        .Day_done(Day_done)
    );

    multi_phase_controller #(.ONE_SECOND(OS), .NUM_PHASES(4)) u_dut4 (
        .clk(clk), .n_rst(n_rst),
        .bt_start(bt_start), .bt_setting(bt_setting), .bt_abort(bt_abort),
        .rx_data(rx_data), .rx_done(rx_done),
        .led_data(led_data), .spi_done(spi_done),
        .spi_req(spi_req4), .motor_signal(motor4),
        .heat_signal(heat4), .led_out(led4),
        .remain_sec(remain4), .phase_active(pa4),
        .Day_done(done4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_ph = 0; m_light = 0; m_run = 10; m_left = 0;
        m_ps = 0; m_pse = 0; m_pa = 0;
    endtask

    // Behaviour in terms of total cycles left in the running phase.
    task automatic model_step();
        bit es, ss, as;
        es = bt_start && !m_ps;
        ss = bt_setting && !m_pse;
        as = bt_abort && !m_pa;
        m_ps = bt_start; m_pse = bt_setting; m_pa = bt_abort;
        if (as && m_st != M_IDLE) begin
            m_st = M_IDLE; m_ph = 0; m_left = 0;
        end else begin
            case (m_st)
                M_IDLE, M_DONE: if (es) begin m_st = M_LR; m_ph = 0; end
                M_LR: if (spi_done) begin m_light = int'(led_data); m_st = M_DISP; end
                M_DISP: m_st = M_SET;
                M_SET: begin
                    if (rx_done) m_run = (rx_data == 0) ? 10 : int'(rx_data);
                    if (ss) begin m_st = M_RUN; m_left = m_run * OS; end
                end
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_ph == NP - 1) m_st = M_DONE;
                        else begin m_ph++; m_st = M_LR; end
                    end
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic model_check();
        bit inp;
        inp = (m_st >= M_LR) && (m_st <= M_RUN);
        chk("m_spi_req", int'(spi_req), int'(m_st == M_LR));
        chk("m_motor", int'(motor_signal), int'(m_st == M_RUN));
        chk("m_heat", int'(heat_signal), int'(m_st == M_RUN && m_light < 128));
        chk("m_led_out", int'(led_out), m_light);
        chk("m_remain", int'(remain_sec), (m_st == M_RUN) ? (m_left + OS - 1) / OS : 0);
        chk("m_phase_active", int'(phase_active), inp ? (1 << m_ph) : 0);
        chk("m_day_done", int'(Day_done), int'(m_st == M_DONE));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (mchk) model_check();
    endtask

    // Called at a falling edge; reset is asynchronous so outputs clear at once.
    task automatic do_reset();
        n_rst = 1'b0;
        bt_start = 0; bt_setting = 0; bt_abort = 0;
        rx_done = 0; spi_done = 0; rx_data = 0; led_data = 0;
        #2;
        chk("rst_outputs", int'({spi_req, motor_signal, heat_signal, Day_done,
            led_out, remain_sec, phase_active}), 0);
        chk("rst_outputs4", int'({spi_req4, motor4, heat4, done4,
            led4, remain4, pa4}), 0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic press_start();
        bt_start = 1; tick(); bt_start = 0;
    endtask

    task automatic spi(input logic [7:0] v);
        led_data = v; spi_done = 1; tick(); spi_done = 0; tick();
    endtask

    task automatic set_go(input bit rv, input logic [7:0] v);
        rx_done = rv; rx_data = v; bt_setting = 1; tick();
        rx_done = 0; bt_setting = 0;
    endtask

    task automatic count_run(input int exp, input string name);
        int cyc;
        cyc = 0;
        while (motor_signal && cyc < 3000) begin
            if (cyc % OS == 0) chk({name, "_remain"}, int'(remain_sec), exp / OS - cyc / OS);
            tick();
            cyc++;
        end
        chk(name, cyc, exp);
        chk({name, "_end_remain"}, int'(remain_sec), 0);
    endtask

    typedef struct {
        int n;
        bit st, se, ab, rxv;
        logic [7:0] rxd;
        bit spd;
        logic [7:0] led;
        bit e_spi, e_mot, e_heat;
        logic [7:0] e_led, e_rem;
        logic [1:0] e_pa;
        bit e_dd;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1,  0,0,0,0,8'd0,0,8'h00, 0,0,0,8'h00,8'd0,2'b00,0};
        tbl[1]  = '{1,  1,0,0,0,8'd0,0,8'h00, 1,0,0,8'h00,8'd0,2'b01,0};
        tbl[2]  = '{3,  1,0,0,0,8'd0,0,8'h00, 1,0,0,8'h00,8'd0,2'b01,0};
        tbl[3]  = '{1,  0,0,0,0,8'd0,1,8'h40, 0,0,0,8'h40,8'd0,2'b01,0};
        tbl[4]  = '{1,  0,0,0,0,8'd0,0,8'h00, 0,0,0,8'h40,8'd0,2'b01,0};
        tbl[5]  = '{1,  0,0,0,1,8'd2,0,8'h00, 0,0,0,8'h40,8'd0,2'b01,0};
        tbl[6]  = '{1,  0,1,0,0,8'd0,0,8'h00, 0,1,1,8'h40,8'd2,2'b01,0};
        tbl[7]  = '{9,  0,1,0,0,8'd0,0,8'h00, 0,1,1,8'h40,8'd2,2'b01,0};
        tbl[8]  = '{1,  0,0,0,0,8'd0,0,8'h00, 0,1,1,8'h40,8'd1,2'b01,0};
        tbl[9]  = '{10, 0,0,0,0,8'd0,0,8'h00, 1,0,0,8'h40,8'd0,2'b10,0};
        tbl[10] = '{1,  0,0,0,0,8'd0,1,8'hF0, 0,0,0,8'hF0,8'd0,2'b10,0};
        tbl[11] = '{1,  0,0,0,0,8'd0,0,8'h00, 0,0,0,8'hF0,8'd0,2'b10,0};
        tbl[12] = '{1,  0,1,0,0,8'd0,0,8'h00, 0,1,0,8'hF0,8'd2,2'b10,0};
        tbl[13] = '{20, 0,0,0,0,8'd0,0,8'h00, 0,0,0,8'hF0,8'd0,2'b00,1};
        tbl[14] = '{1,  1,0,0,0,8'd0,0,8'h00, 1,0,0,8'hF0,8'd0,2'b01,0};
        tbl[15] = '{1,  0,0,1,0,8'd0,0,8'h00, 0,0,0,8'hF0,8'd0,2'b00,0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            bt_start = tbl[i].st; bt_setting = tbl[i].se; bt_abort = tbl[i].ab;
            rx_done = tbl[i].rxv; rx_data = tbl[i].rxd;
            spi_done = tbl[i].spd; led_data = tbl[i].led;
            repeat (tbl[i].n) tick();
            chk($sformatf("v%0d_spi", i), int'(spi_req), int'(tbl[i].e_spi));
            chk($sformatf("v%0d_motor", i), int'(motor_signal), int'(tbl[i].e_mot));
            chk($sformatf("v%0d_heat", i), int'(heat_signal), int'(tbl[i].e_heat));
            chk($sformatf("v%0d_led", i), int'(led_out), int'(tbl[i].e_led));
            chk($sformatf("v%0d_remain", i), int'(remain_sec), int'(tbl[i].e_rem));
            chk($sformatf("v%0d_pa", i), int'(phase_active), int'(tbl[i].e_pa));
            chk($sformatf("v%0d_done", i), int'(Day_done), int'(tbl[i].e_dd));
        end
        bt_abort = 0; spi_done = 0; rx_done = 0; tick();

        // Default run time after reset, and a zero byte mapping to it.
        do_reset();
        press_start();
        spi(8'h40);
        set_go(0, 8'd0);
        count_run(100, "run_default");
        spi(8'hF0);
        rx_done = 1; rx_data = 8'd0; tick(); rx_done = 0;
        set_go(0, 8'd0);
        count_run(100, "run_zero_byte");
        chk("day_done_default", int'(Day_done), 1);

        // Byte arriving together with the setting edge.
        press_start();
        spi(8'h40);
        set_go(1, 8'd2);
        count_run(20, "run_same_cycle_rx");

        // Abort mid-run, then restart.
        bt_abort = 1; tick(); bt_abort = 0; tick();
        press_start();
        spi(8'h40);
        set_go(1, 8'd3);
        repeat (5) tick();
        bt_abort = 1; tick(); bt_abort = 0;
        chk("abort_motor", int'(motor_signal), 0);
        chk("abort_heat", int'(heat_signal), 0);
        chk("abort_pa", int'(phase_active), 0);
        chk("abort_led_hold", int'(led_out), 8'h40);
        press_start();
        chk("restart_spi", int'(spi_req), 1);
        chk("restart_pa", int'(phase_active), 1);

        // Ignored spi in SETTING, held setting and start toggles while running.
        spi(8'h40);
        led_data = 8'hFF; spi_done = 1; tick(); spi_done = 0;
        chk("spi_ignored_led", int'(led_out), 8'h40);
        begin
            int mc;
            mc = 0;
            bt_setting = 1; rx_done = 1; rx_data = 8'd1;
            for (int k = 0; k < 50; k++) begin
                tick();
                rx_done = 0;
                bt_start = k[0];
                if (motor_signal) mc++;
            end
            chk("held_setting_runs", mc, 10);
        end
        bt_setting = 0; bt_start = 0; tick();
        bt_abort = 1; tick(); bt_abort = 0;
        bt_start = 1;
        repeat (50) tick();
        chk("held_start_pa", int'(phase_active), 1);
        bt_start = 0; tick();

        // Four-phase instance sequencing.
        do_reset();
        press_start();
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("pa4_phase%0d", p), int'(pa4), 1 << p);
            spi(8'h20);
            set_go(1, 8'd1);
            repeat (OS) tick();
        end
        chk("pa4_done_level", int'(done4), 1);
        chk("pa4_done_pa", int'(pa4), 0);
        press_start();
        chk("pa4_newday", int'(pa4), 1);
        chk("pa4_newday_done", int'(done4), 0);

        // Random traffic against the model, with one reset mid-run.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if (k == 2000) do_reset();
            if ($urandom_range(0, 7) == 0) bt_start = ~bt_start;
            if ($urandom_range(0, 5) == 0) bt_setting = ~bt_setting;
            bt_abort = ($urandom_range(0, 299) == 0);
            rx_done = ($urandom_range(0, 4) == 0);
            rx_data = 8'($urandom_range(0, 3));
            spi_done = ($urandom_range(0, 3) == 0);
            led_data = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
